// File: rtl/obi_spi_pkg.sv
// Shared definitions for the OBI-attached SPI master.
// Contents: register byte offsets and their word indices (addr[4:2]),
// CTRL / STATUS bit positions, the control-field struct and the FSM state enum.
package obi_spi_pkg;

  // Register byte offsets within the peripheral window
  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_TX     = 5'h04;
  localparam logic [4:0] OFF_STATUS = 5'h08;
  localparam logic [4:0] OFF_DIV    = 5'h0C;
  localparam logic [4:0] OFF_RX     = 5'h10;

  // Word indices as decoded from addr[4:2]
  localparam logic [2:0] IDX_CTRL   = OFF_CTRL[4:2];
  localparam logic [2:0] IDX_TX     = OFF_TX[4:2];
  localparam logic [2:0] IDX_STATUS = OFF_STATUS[4:2];
  localparam logic [2:0] IDX_DIV    = OFF_DIV[4:2];
  localparam logic [2:0] IDX_RX     = OFF_RX[4:2];

  // CTRL bit positions
  localparam int CTRL_START = 0;
  localparam int CTRL_CPOL  = 1;
  localparam int CTRL_CPHA  = 2;
  localparam int CTRL_LSB   = 3;
  localparam int CTRL_CS_LO = 4;
  localparam int CTRL_CS_HI = 5;

  // STATUS bit positions
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  // Persistent CTRL fields; packed so that it maps onto CTRL[5:1] directly
  typedef struct packed {
    logic [1:0] cs_sel;
    logic       lsb_first;
    logic       cpha;
    logic       cpol;
  } spi_ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

endpackage

// File: rtl/obi_spi_master_clkgen.sv
// Half-period tick generator for the SPI master (module spi_clkgen).
// Ports:
//   clk_i, rst_ni : clock and asynchronous active-low reset
//   en            : counting enable; while low the counter is held at zero
//   div           : divider value; a tick fires every div+1 enabled cycles
//   tick          : one-cycle strobe marking the end of a half-period
// Because the counter is held at zero while disabled, the first tick after
// enable rises arrives exactly div+1 cycles later.
module spi_clkgen #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;

  assign tick = en && (cnt_q == div);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (!en || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/obi_spi_master.sv
// OBI slave exposing a single-frame SPI master.
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   req_i, we_i, addr_i,
//   wdata_i                  : OBI request (always granted, gnt_o = req_i)
//   gnt_o, rvalid_o, rdata_o : OBI response, rvalid one cycle after request
//   sck_o, mosi_o, cs_no     : SPI outputs, all driven from flops
//   miso_i                   : SPI serial input
// Registers (addr[4:2]): CTRL, TX, STATUS, DIV, RX.
// A transfer is SETUP (one half-period), SHIFT (2*DATA_W sck edges, one per
// half-period) and HOLD (one half-period); the half-period is DIV+1 cycles.
module obi_spi_master
  import obi_spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 1,
  parameter int DIV_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              sck_o,
  output logic              mosi_o,
  output logic [NUM_CS-1:0] cs_no,
  input  logic              miso_i
);

  localparam int EDGE_W = $clog2(2 * DATA_W);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

  spi_state_e        state_q, state_d;
  spi_ctrl_t         ctrl_q, ctrl_d;
  logic [DATA_W-1:0] tx_q, rx_q, tx_sh_q, rx_sh_q;
  logic [DIV_W-1:0]  div_q;
  logic [EDGE_W-1:0] edge_q;
  logic              done_q;
  logic              sck_q, mosi_q;
  logic [NUM_CS-1:0] cs_q;
  logic              rvalid_q;
  logic [31:0]       rdata_q, rdata_d;

  logic       busy, tick;
  logic       wr, rd;
  logic [2:0] idx;
  logic       wr_ctrl, wr_tx, wr_div, rd_rx, start;
  logic       shift_tick, shift_edge;
  logic       unused_bits;

  // Bit-order helpers: the next bit to send, the register after sending it,
  // and the receive register after taking in one bit.
  function automatic logic first_bit(input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? d[0] : d[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] d,
                                                  input logic lsb);
    return lsb ? (d >> 1) : (d << 1);
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] d,
                                                 input logic b, input logic lsb);
    return lsb ? {b, d[DATA_W-1:1]} : {d[DATA_W-2:0], b};
  endfunction

  // Active-low select for one chip select; an out-of-range selection
  // leaves every line deasserted.
  function automatic logic [NUM_CS-1:0] cs_mask(input logic [1:0] sel);
    logic [NUM_CS-1:0] m;
    m = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (sel == 2'(i)) m[i] = 1'b0;
    end
    return m;
  endfunction

  // Only a handful of address/data bits are decoded
  assign unused_bits = ^{addr_i, wdata_i};

  assign gnt_o    = req_i;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign sck_o    = sck_q;
  assign mosi_o   = mosi_q;
  assign cs_no    = cs_q;

  assign busy = (state_q != ST_IDLE);

  // Bus decode
  assign wr      = req_i && we_i;
  assign rd      = req_i && !we_i;
  assign idx     = addr_i[4:2];
  assign wr_ctrl = wr && (idx == IDX_CTRL);
  assign wr_tx   = wr && (idx == IDX_TX);
  assign wr_div  = wr && (idx == IDX_DIV);
  assign rd_rx   = rd && (idx == IDX_RX);
  assign start   = wr_ctrl && wdata_i[CTRL_START] && !busy;

  // Configuration written together with START takes effect for that transfer
  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_ctrl && !busy) begin
      ctrl_d = spi_ctrl_t'(wdata_i[CTRL_CS_HI:CTRL_CPOL]);
    end
  end

  // Even-indexed edges are leading. With CPHA=0 data moves on trailing edges,
  // with CPHA=1 on leading edges; the other edge of each pair samples miso.
  assign shift_tick = (state_q == ST_SHIFT) && tick;
  assign shift_edge = (!edge_q[0]) == ctrl_q.cpha;

  spi_clkgen #(
    .DIV_W(DIV_W)
  ) u_clkgen (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en    (busy),
    .div   (div_q),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_SETUP;
      ST_SETUP: if (tick) state_d = ST_SHIFT;
      ST_SHIFT: if (tick && (edge_q == LAST_EDGE)) state_d = ST_HOLD;
      ST_HOLD:  if (tick) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Software-visible registers; writes are dropped while a transfer runs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q <= '0;
      tx_q   <= '0;
      div_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      if (wr_tx && !busy)  tx_q  <= wdata_i[DATA_W-1:0];
      if (wr_div && !busy) div_q <= wdata_i[DIV_W-1:0];
    end
  end

  // Shift datapath. With CPHA=0 the first bit is already on mosi when
  // SETUP begins, so the shift register starts one bit ahead.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      edge_q  <= '0;
      mosi_q  <= 1'b0;
    end else if (start) begin
      tx_sh_q <= ctrl_d.cpha ? tx_q : shift_out(tx_q, ctrl_d.lsb_first);
      rx_sh_q <= '0;
      edge_q  <= '0;
      if (!ctrl_d.cpha) mosi_q <= first_bit(tx_q, ctrl_d.lsb_first);
    end else if (shift_tick) begin
      edge_q <= edge_q + EDGE_W'(1);
      if (shift_edge) begin
        mosi_q  <= first_bit(tx_sh_q, ctrl_q.lsb_first);
        tx_sh_q <= shift_out(tx_sh_q, ctrl_q.lsb_first);
      end else begin
        rx_sh_q <= shift_in(rx_sh_q, miso_i, ctrl_q.lsb_first);
      end
    end
  end

  // RX capture and DONE; setting DONE wins over a coincident RX read
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_q   <= '0;
      done_q <= 1'b0;
    end else if ((state_q == ST_HOLD) && tick) begin
      rx_q   <= rx_sh_q;
      done_q <= 1'b1;
    end else if (start || rd_rx) begin
      done_q <= 1'b0;
    end
  end

  // SPI pins. sck rests at CPOL and toggles on each SHIFT tick; the even
  // number of edges leaves it back at CPOL on entry to HOLD. Chip selects
  // follow the next state so they line up with BUSY.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_q <= 1'b0;
      cs_q  <= '1;
    end else begin
      if (state_q == ST_SHIFT) begin
        if (tick) sck_q <= ~sck_q;
      end else begin
        sck_q <= ctrl_d.cpol;
      end
      cs_q <= (state_d != ST_IDLE) ? cs_mask(ctrl_d.cs_sel) : '1;
    end
  end

  // Read mux; writes and unmapped offsets return zero
  always_comb begin
    rdata_d = '0;
    if (rd) begin
      unique case (idx)
        IDX_CTRL:   rdata_d = {26'b0, ctrl_q.cs_sel, ctrl_q.lsb_first,
                               ctrl_q.cpha, ctrl_q.cpol, 1'b0};
        IDX_TX:     rdata_d = 32'(tx_q);
        IDX_STATUS: rdata_d = {30'b0, done_q, busy};
        IDX_DIV:    rdata_d = 32'(div_q);
        IDX_RX:     rdata_d = 32'(rx_q);
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= req_i;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_obi_spi_master.sv
module tb_obi_spi_master;

  localparam int DW = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic        sck, mosi, miso;
  logic [3:0]  cs_n;
  logic        loop_en, miso_val;

  logic        unused_gnt2, unused_rvalid2, unused_sck2, unused_mosi2;
  logic [31:0] unused_rdata2;
  logic [1:0]  cs2_n;

  always #5 clk = ~clk;

  assign miso = loop_en ? mosi : miso_val;

  obi_spi_master #(.DATA_W(DW), .NUM_CS(4), .DIV_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .sck_o(sck), .mosi_o(mosi), .cs_no(cs_n), .miso_i(miso)
  );

  // Second instance on the same bus with only two chip selects
  obi_spi_master #(.DATA_W(DW), .NUM_CS(2), .DIV_W(16)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(unused_gnt2), .rvalid_o(unused_rvalid2),
    .rdata_o(unused_rdata2), .sck_o(unused_sck2), .mosi_o(unused_mosi2),
    .cs_no(cs2_n), .miso_i(1'b0)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Line monitor: counts sck edges, records mosi at the slave's sampling
  // edge, and tracks chip-select activity.
  logic       prev_sck = 1'b0;
  logic       m_cpol = 1'b0, m_cpha = 1'b0;
  logic [3:0] m_cs_exp = 4'hF;
  logic [1:0] m_cs2_exp = 2'b11;
  int edges = 0, cs_cyc = 0, cs_bad = 0, cs2_cyc = 0, cs2_bad = 0;
  bit mq[$];

  always @(negedge clk) begin
    if (sck !== prev_sck) begin
      edges <= edges + 1;
      if ((prev_sck == m_cpol) ^ m_cpha) mq.push_back(mosi);
    end
    prev_sck <= sck;
    if (cs_n != 4'hF) begin
      cs_cyc <= cs_cyc + 1;
      if (cs_n != m_cs_exp) cs_bad <= cs_bad + 1;
    end
    if (cs2_n != 2'b11) begin
      cs2_cyc <= cs2_cyc + 1;
      if (cs2_n != m_cs2_exp) cs2_bad <= cs2_bad + 1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    #1 chk("gnt_w", {31'b0, gnt}, 32'd1);
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    chk("rvalid_w", {31'b0, rvalid}, 32'd1);
    chk("rdata_w", rdata, 32'd0);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    req = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1;
    req = 1'b0;
    chk("rvalid_r", {31'b0, rvalid}, 32'd1);
    d = rdata;
  endtask

  // One complete transfer with expectations derived from the frame rules:
  // bit order, 2*DW edges, (2*DW+2)*(DIV+1) busy cycles, received word.
  task automatic run_xfer(input logic [7:0] tx, input logic cpol, input logic cpha,
                          input logic lsb, input logic [1:0] cs_sel,
                          input logic [15:0] div, input logic lp,
                          input logic mval, input logic inj);
    logic [31:0] mode, st, d;
    logic [7:0]  exp_rx;
    int e0, q0, c0, cb0, c20, cb20, dur, busy_n;
    mode = {26'b0, cs_sel, lsb, cpha, cpol, 1'b0};
    bus_write(32'h0C, {16'b0, div});
    bus_write(32'h04, {24'b0, tx});
    bus_write(32'h00, mode);
    idle(2);
    chk("sck_idle", {31'b0, sck}, {31'b0, cpol});
    loop_en = lp; miso_val = mval;
    m_cpol = cpol; m_cpha = cpha;
    m_cs_exp  = ~(4'b0001 << cs_sel);
    m_cs2_exp = (cs_sel < 2) ? ~(2'b01 << cs_sel) : 2'b11;
    e0 = edges; q0 = mq.size(); c0 = cs_cyc; cb0 = cs_bad; c20 = cs2_cyc; cb20 = cs2_bad;
    dur = (2 * DW + 2) * (int'(div) + 1);
    exp_rx = lp ? tx : (mval ? 8'hFF : 8'h00);
    bus_write(32'h00, mode | 32'd1);
    busy_n = 0; st = '0;
    for (int k = 0; k < 1000; k++) begin
      if (inj && k == 3) begin
        bus_write(32'h04, 32'hFF);
        bus_write(32'h00, mode | 32'd1);
        busy_n += 2;
      end
      bus_read(32'h08, st);
      if (st[0]) busy_n++;
      else if (busy_n > 0) break;
    end
    chk("busy_cycles", busy_n, dur);
    chk("status_done", st, 32'd2);
    chk("sck_edges", edges - e0, 2 * DW);
    chk("mosi_count", mq.size() - q0, DW);
    for (int i = 0; i < DW; i++) begin
      if (q0 + i < mq.size())
        chk("mosi_bit", {31'b0, mq[q0+i]}, {31'b0, lsb ? tx[i] : tx[DW-1-i]});
    end
    chk("cs_cycles", cs_cyc - c0, dur);
    chk("cs_pattern", cs_bad - cb0, 0);
    chk("cs2_cycles", cs2_cyc - c20, (cs_sel < 2) ? dur : 0);
    chk("cs2_pattern", cs2_bad - cb20, 0);
    bus_read(32'h10, d);
    chk("rx", d, {24'b0, exp_rx});
    bus_read(32'h08, d);
    chk("done_clr", d, 32'd0);
    bus_read(32'h04, d);
    chk("tx_readback", d, {24'b0, tx});
    bus_read(32'h00, d);
    chk("ctrl_readback", d, mode);
    idle(8);
    chk("no_extra_edges", edges - e0, 2 * DW);
    bus_read(32'h08, d);
    chk("idle_after", d, 32'd0);
  endtask

  initial begin
    logic [31:0] d, r;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    loop_en = 1'b1; miso_val = 1'b0;
    #12;
    chk("rst_cs", {28'b0, cs_n}, 32'hF);
    chk("rst_cs2", {30'b0, cs2_n}, 32'h3);
    chk("rst_sck", {31'b0, sck}, 32'd0);
    chk("rst_mosi", {31'b0, mosi}, 32'd0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("gnt_idle", {31'b0, gnt}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    bus_read(32'h00, d); chk("rst_ctrl", d, 32'd0);
    bus_read(32'h04, d); chk("rst_tx", d, 32'd0);
    bus_read(32'h08, d); chk("rst_status", d, 32'd0);
    bus_read(32'h0C, d); chk("rst_div", d, 32'd0);
    bus_read(32'h10, d); chk("rst_rx", d, 32'd0);
    bus_read(32'h18, d); chk("unmapped", d, 32'd0);
    idle(1);
    chk("rvalid_drop", {31'b0, rvalid}, 32'd0);

    // Directed frames
    run_xfer(8'hA5, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b1, 1'b0, 1'b0);
    run_xfer(8'h3C, 1'b1, 1'b1, 1'b0, 2'd1, 16'd3, 1'b0, 1'b1, 1'b0);
    run_xfer(8'h01, 1'b0, 1'b0, 1'b1, 2'd3, 16'd1, 1'b1, 1'b0, 1'b0);
    run_xfer(8'h5A, 1'b0, 1'b1, 1'b0, 2'd0, 16'd2, 1'b1, 1'b0, 1'b1);
    run_xfer(8'hC3, 1'b0, 1'b0, 1'b0, 2'd2, 16'd0, 1'b1, 1'b0, 1'b0);

    // Randomized frames
    for (int n = 0; n < 6; n++) begin
      r = $urandom;
      run_xfer(r[7:0], r[8], r[9], r[10], r[12:11], {14'b0, r[14:13]},
               r[15], r[16], 1'b0);
    end

    // Reset asserted in the middle of SHIFT
    bus_write(32'h0C, 32'd3);
    bus_write(32'h04, 32'h96);
    bus_write(32'h00, 32'h13);
    idle(20);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cs", {28'b0, cs_n}, 32'hF);
    chk("mid_rst_sck", {31'b0, sck}, 32'd0);
    chk("mid_rst_mosi", {31'b0, mosi}, 32'd0);
    chk("mid_rst_rvalid", {31'b0, rvalid}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    bus_read(32'h08, d); chk("mid_rst_status", d, 32'd0);
    bus_read(32'h10, d); chk("mid_rst_rx", d, 32'd0);
    bus_read(32'h00, d); chk("mid_rst_ctrl", d, 32'd0);
    bus_read(32'h04, d); chk("mid_rst_tx", d, 32'd0);
    bus_read(32'h0C, d); chk("mid_rst_div", d, 32'd0);
    idle(40);
    bus_read(32'h08, d); chk("mid_rst_stays_idle", d, 32'd0);
    chk("mid_rst_cs_idle", {28'b0, cs_n}, 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/obi_spi_master.md
OBI_SPI_MASTER -- requirements
Module: obi_spi_master

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the frame width in bits (legal range 4..32).
REQ-002 SHALL have parameter NUM_CS, default 1, giving the number of chip selects (legal range 1..4).
REQ-003 SHALL have parameter DIV_W, default 16, giving the width of the clock divider register.
REQ-004 SHALL have port clk_i, input, width 1: clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_ni, input, width 1: reset, asynchronous, active-low.
REQ-006 SHALL have ports req_i, we_i, addr_i[31:0] and wdata_i[31:0], all inputs, forming the OBI request.
REQ-007 SHALL have ports gnt_o, rvalid_o and rdata_o[31:0], all outputs, forming the OBI response.
REQ-008 SHALL have outputs sck_o (1), mosi_o (1) and cs_no[NUM_CS-1:0], where cs_no is active-low, plus input miso_i (1).

Function
REQ-009 SHALL drive gnt_o = req_i combinationally.
REQ-010 SHALL pulse rvalid_o for exactly one cycle, one cycle after every granted request (read or write); rdata_o is valid in that cycle and is 0 for writes and unmapped offsets.
REQ-011 SHALL decode addr_i[4:2] into these registers:
- 0x00 CTRL (RW): [0] START (write-1, reads 0), [1] CPOL, [2] CPHA, [3] LSB_FIRST, [5:4] CS_SEL.
- 0x04 TX (RW), DATA_W bits.
- 0x08 STATUS (RO): [0] BUSY, [1] DONE.
- 0x0C DIV (RW), DIV_W bits.
- 0x10 RX (RO), DATA_W bits.
REQ-012 SHALL drop writes to CTRL, TX and DIV while BUSY=1; a START issued while BUSY=1 is ignored.
REQ-013 SHALL clear DONE on a write to CTRL with START=1, and also on a read of RX.
REQ-014 SHALL define the half-period as DIV+1 clk_i cycles; DIV=0 gives one clk_i cycle.
REQ-015 SHALL implement FSM states IDLE, SETUP, SHIFT and HOLD:
- IDLE->SETUP on an accepted START.
- SETUP->SHIFT after one half-period.
- SHIFT->HOLD after 2*DATA_W sck edges.
- HOLD->IDLE after one half-period.
REQ-016 SHALL assert BUSY in SETUP, SHIFT and HOLD, first in the cycle after the START write.
REQ-017 SHALL set DONE and load RX in the same cycle as the HOLD->IDLE transition.
REQ-018 SHALL drive cs_no[CS_SEL] low during SETUP, SHIFT and HOLD and hold all other chip selects high; a CS_SEL >= NUM_CS drives no chip select but the transfer still runs.
REQ-019 SHALL drive sck_o = CPOL outside SHIFT and toggle it once per half-period during SHIFT.
REQ-020 SHALL, when CPHA=0, drive the first bit on mosi_o at entry to SETUP, sample miso_i on odd-numbered edges (leading), and shift on even-numbered edges (trailing).
REQ-021 SHALL, when CPHA=1, shift on leading edges and sample on trailing edges, presenting the first bit on mosi_o at the first edge.
REQ-022 SHALL transmit and receive MSB first when LSB_FIRST=0 and LSB first otherwise.
REQ-023 SHALL register sck_o, mosi_o and cs_no with no combinational path from clk_i.
REQ-024 SHALL take exactly (2*DATA_W+2)*(DIV+1) cycles per transfer, measured from the first BUSY cycle to the first cycle after BUSY deasserts.
REQ-025 SHALL, when a read of RX and the DONE set occur in the same cycle, leave DONE set.

Reset
REQ-026 SHALL, on rst_ni low, immediately put the FSM in IDLE and reset:
- cs_no to all ones, sck_o to 0, mosi_o to 0;
- rvalid_o to 0;
- CTRL, TX, DIV, RX, BUSY and DONE to 0.
REQ-027 SHALL abort any transfer in progress on a reset asserted mid-transfer, with no DONE and no RX update.

Structure
REQ-028 SHALL place register offsets, CTRL bit positions and the state enum in package obi_spi_pkg.
REQ-029 SHALL implement the half-period tick counter as sub-module spi_clkgen (DIV_W parameter, enable input, tick output).

Verification
REQ-030 SHALL cover: DATA_W=8, DIV=0, mode 0, TX=0xA5, miso looped to mosi -> mosi_o bits 1,0,1,0,0,1,0,1 on leading edges; RX=0xA5, DONE=1, transfer lasting 18 cycles.
REQ-031 SHALL cover: DIV=3, CPOL=1, CPHA=1, TX=0x3C, miso tied to 1 -> sck idles high, half-period 4 cycles, RX=0xFF, BUSY high for 72 cycles.
REQ-032 SHALL cover: LSB_FIRST=1, TX=0x01 -> first mosi_o bit is 1 and the remaining seven bits are 0.
REQ-033 SHALL cover: writes TX=0xFF and START while BUSY -> the in-flight frame is unchanged, no second transfer occurs, and TX reads back its old value.
REQ-034 SHALL cover: NUM_CS=4, CS_SEL=2 -> cs_no=4'b1011 during the transfer and 4'b1111 otherwise; CS_SEL=3 with NUM_CS=2 -> cs_no stays all ones.
REQ-035 SHALL cover: rst_ni pulsed low mid-SHIFT -> cs_no all ones, sck_o=0, BUSY=0 and DONE=0 immediately.
